// File: rtl/sfu_pkg.sv
// Shared types and lane arithmetic for the PMEM psum accumulator.
// The saturating add and ReLU are defined at the default psum width.
package sfu_pkg;

    localparam int unsigned PSUM_BW = 16;
    localparam int unsigned COL     = 8;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        WB,
        FIN
    } acc_state_t;

    // Add with a one-bit guard; a sign disagreement between guard and MSB marks overflow.
    function automatic logic [PSUM_BW-1:0] sat_add(input logic [PSUM_BW-1:0] a,
                                                   input logic [PSUM_BW-1:0] b);
        logic [PSUM_BW:0] s;
        s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
        if (s[PSUM_BW] != s[PSUM_BW-1]) begin
            return s[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
        end
        return s[PSUM_BW-1:0];
    endfunction

    function automatic logic [PSUM_BW-1:0] relu(input logic [PSUM_BW-1:0] x);
        return x[PSUM_BW-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/sfu_lane.sv
// One psum lane: overwrite or saturating accumulate, then optional ReLU.
module sfu_lane
    import sfu_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW
) (
    input  logic [psum_bw-1:0] data,
    input  logic [psum_bw-1:0] q,
    input  logic               first,
    input  logic               last,
    output logic [psum_bw-1:0] wdata
);

    logic [psum_bw-1:0] v;

    always_comb begin
        v     = first ? data : sat_add(data, q);
        wdata = last ? relu(v) : v;
    end

endmodule

// File: rtl/psum_accumulator.sv
// Pops OFIFO rows and read-modify-writes them into PMEM, one row per address,
// at two cycles per row (POP issues the read, WB writes the combined value).
module psum_accumulator
    import sfu_pkg::*;
#(
    parameter int unsigned col     = COL,
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned nrow    = 16,
    parameter int unsigned addr_bw = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     kij_first,
    input  logic                     kij_last,
    input  logic [addr_bw-1:0]       base_addr,
    output logic                     busy,
    output logic                     done,
    input  logic [psum_bw*col-1:0]   ofifo_out,
    input  logic                     ofifo_valid,
    output logic                     ofifo_rd,
    input  logic [psum_bw*col-1:0]   mem_q,
    output logic [psum_bw*col-1:0]   mem_d,
    output logic [addr_bw-1:0]       mem_addr,
    output logic                     mem_cen,
    output logic                     mem_wen
);

    localparam int unsigned      CNT_W    = (nrow > 1) ? $clog2(nrow) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(nrow - 1);

    acc_state_t               state;
    acc_state_t               state_next;
    logic [CNT_W-1:0]         row_cnt;
    logic                     first_r;
    logic                     last_r;
    logic [addr_bw-1:0]       base_r;
    logic [addr_bw-1:0]       row_addr;
    logic [psum_bw*col-1:0]   data_r;
    logic [psum_bw*col-1:0]   wdata;

    // Wraps naturally modulo 2^addr_bw.
    assign row_addr = base_r + addr_bw'(row_cnt);

    for (genvar i = 0; i < col; i++) begin : g_lane
        sfu_lane #(
            .psum_bw(psum_bw)
        ) u_lane (
            .data (data_r[i*psum_bw +: psum_bw]),
            .q    (mem_q[i*psum_bw +: psum_bw]),
            .first(first_r),
            .last (last_r),
            .wdata(wdata[i*psum_bw +: psum_bw])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            row_cnt <= '0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
            base_r  <= '0;
            data_r  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        first_r <= kij_first;
                        last_r  <= kij_last;
                        base_r  <= base_addr;
                        row_cnt <= '0;
                    end
                end
                POP: begin
                    if (ofifo_valid) begin
                        data_r <= ofifo_out;
                    end
                end
                WB: begin
                    if (row_cnt != LAST_ROW) begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        ofifo_rd   = 1'b0;
        mem_cen    = 1'b1;
        mem_wen    = 1'b1;
        mem_addr   = '0;
        mem_d      = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = POP;
                end
            end
            POP: begin
                if (ofifo_valid) begin
                    ofifo_rd   = 1'b1;
                    state_next = WB;
                    if (!first_r) begin
                        mem_cen  = 1'b0;
                        mem_addr = row_addr;
                    end
                end
            end
            WB: begin
                mem_cen    = 1'b0;
                mem_wen    = 1'b0;
                mem_addr   = row_addr;
                mem_d      = wdata;
                state_next = (row_cnt == LAST_ROW) ? FIN : POP;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with a behavioural 1-cycle-latency PMEM.
module tb_psum_accumulator;

    localparam int NROW = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         kij_first;
    logic         kij_last;
    logic [8:0]   base_addr;
    logic         busy;
    logic         done;
    logic [127:0] ofifo_out;
    logic         ofifo_valid;
    logic         ofifo_rd;
    logic [127:0] mem_q;
    logic [127:0] mem_d;
    logic [8:0]   mem_addr;
    logic         mem_cen;
    logic         mem_wen;

    logic [127:0] pmem [512];
    logic [127:0] rows [NROW];
    logic [127:0] exp_w [NROW];
    logic         fill_en = 1'b0;
    logic [8:0]   fill_base = '0;
    logic [127:0] fill_val = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    psum_accumulator #(
        .col    (8),
        .psum_bw(16),
        .nrow   (16),
        .addr_bw(9)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .kij_first  (kij_first),
        .kij_last   (kij_last),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
        .ofifo_out  (ofifo_out),
        .ofifo_valid(ofifo_valid),
        .ofifo_rd   (ofifo_rd),
        .mem_q      (mem_q),
        .mem_d      (mem_d),
        .mem_addr   (mem_addr),
        .mem_cen    (mem_cen),
        .mem_wen    (mem_wen)
    );

    always @(posedge clk) begin
        if (fill_en) begin
            for (int k = 0; k < NROW; k++) pmem[9'(fill_base + 9'(k))] <= fill_val;
        end else if (!mem_cen) begin
            if (!mem_wen) pmem[mem_addr] <= mem_d;
            else          mem_q <= pmem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [8:0] base, input logic [127:0] val);
        fill_base = base;
        fill_val  = val;
        fill_en   = 1'b1;
        @(posedge clk);
        #1 fill_en = 1'b0;
    endtask

    // Lane i of row r = r*8+i+offset; expected write is that value, ReLU'd if requested.
    task automatic set_ramp(input int offset, input bit do_relu);
        for (int r = 0; r < NROW; r++) begin
            for (int i = 0; i < 8; i++) begin
                int v;
                v = r * 8 + i + offset;
                rows[r][i*16 +: 16]  = 16'(v);
                exp_w[r][i*16 +: 16] = (do_relu && v < 0) ? 16'd0 : 16'(v);
            end
        end
    endtask

    task automatic set_uniform(input logic [15:0] row_val, input logic [15:0] exp_val);
        for (int r = 0; r < NROW; r++) begin
            rows[r]  = {8{row_val}};
            exp_w[r] = {8{exp_val}};
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 128'({busy, done, ofifo_rd, mem_cen, mem_wen}), 128'(5'b00011));
        check({tag, "_d"}, mem_d, '0);
        check({tag, "_addr"}, 128'(mem_addr), '0);
    endtask

    task automatic run_pass(input string name, input logic first, input logic last,
                            input logic [8:0] base, input int stall_len, input bit illegal,
                            input int abort_at, input int exp_done);
        int cyc = 0, pops = 0, writes = 0, reads = 0, stall_cnt = 0, done_cyc = 0, pop_idx = 0;
        bit prev_rd = 0, prev_read = 0, finished = 0, busy_chk = 0, stalling = 0;
        kij_first   = first;
        kij_last    = last;
        base_addr   = base;
        start       = 1'b1;
        ofifo_valid = 1'b1;
        ofifo_out   = rows[0];
        for (int k = 0; k < 200 && !finished; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            start     = 1'b0;
            kij_first = ~first;
            kij_last  = ~last;
            base_addr = ~base;
            if (prev_rd) pop_idx++;
            stalling    = (stall_len > 0) && (pop_idx == 3) && (stall_cnt < stall_len);
            ofifo_valid = (pop_idx < NROW) && !stalling;
            ofifo_out   = (pop_idx < NROW) ? rows[pop_idx] : '0;
            #1;
            if (busy_chk) begin
                check({name, "_busy_after_ignored_start"}, 128'(busy), 128'(1'b1));
                busy_chk = 0;
            end
            if (stalling && mem_cen) begin
                stall_cnt++;
                check({name, "_stall_rd_cen"}, 128'({ofifo_rd, mem_cen, busy}), 128'(3'b011));
            end
            if (ofifo_rd) begin
                pops++;
                if (!ofifo_valid) check({name, "_rd_without_valid"}, 128'(ofifo_rd), 128'(1'b0));
            end
            if (!mem_cen && mem_wen) begin
                check({name, "_read_on_first"}, 128'(first), 128'(1'b0));
                check($sformatf("%s_raddr%0d", name, reads), 128'(mem_addr), 128'(9'(base + 9'(reads))));
                if (prev_read) check({name, "_read_twice"}, 128'(prev_read), 128'(1'b0));
                prev_read = 1;
                reads++;
            end else if (!mem_cen && !mem_wen) begin
                if (writes == abort_at) begin
                    reset = 1'b0;
                    #1;
                    check_reset_outputs({name, "_abort"});
                    for (int j = 0; j < 3; j++) begin
                        @(posedge clk);
                        #1;
                        check({name, "_abort_nodone"}, 128'({done, busy}), 128'(2'b00));
                    end
                    reset = 1'b1;
                    return;
                end
                check($sformatf("%s_waddr%0d", name, writes), 128'(mem_addr), 128'(9'(base + 9'(writes))));
                check($sformatf("%s_wdata%0d", name, writes), mem_d, exp_w[writes]);
                if (!first) check({name, "_rmw_order"}, 128'(prev_read), 128'(1'b1));
                prev_read = 0;
                writes++;
                if (illegal && writes == 5) begin
                    start    = 1'b1;
                    busy_chk = 1;
                end
            end
            if (done) begin
                done_cyc = cyc;
                finished = 1;
            end
            prev_rd = ofifo_rd;
        end
        check({name, "_done_cycle"}, 128'(done_cyc), 128'(exp_done));
        check({name, "_pops"}, 128'(pops), 128'(NROW));
        check({name, "_writes"}, 128'(writes), 128'(NROW));
        check({name, "_reads"}, 128'(reads), 128'(first ? 0 : NROW));
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #2;
            check({name, "_idle_after"}, 128'({done, busy, ofifo_rd}), 128'(3'b000));
        end
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        kij_first   = 1'b0;
        kij_last    = 1'b0;
        base_addr   = '0;
        ofifo_valid = 1'b0;
        ofifo_out   = '0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        set_ramp(0, 1'b0);
        run_pass("overwrite", 1'b1, 1'b0, 9'd0, 0, 1'b0, NROW, 33);

        fill(9'd32, {8{16'd100}});
        set_uniform(-16'sd30, 16'd70);
        run_pass("accum", 1'b0, 1'b0, 9'd32, 0, 1'b0, NROW, 33);

        fill(9'd64, {8{16'd32000}});
        set_uniform(16'd1000, 16'd32767);
        run_pass("sat_pos", 1'b0, 1'b0, 9'd64, 0, 1'b0, NROW, 33);

        fill(9'd96, {8{-16'sd32000}});
        set_uniform(-16'sd1000, 16'd0);
        run_pass("sat_neg_relu", 1'b0, 1'b1, 9'd96, 0, 1'b0, NROW, 33);

        set_ramp(0, 1'b0);
        run_pass("stall", 1'b1, 1'b0, 9'd128, 5, 1'b0, NROW, 38);

        run_pass("wrap", 1'b1, 1'b0, 9'd504, 0, 1'b1, NROW, 33);
        check("wrap_mem_addr0", pmem[9'd0], exp_w[8]);

        fill(9'd200, {8{16'h5A5A}});
        run_pass("abort", 1'b1, 1'b0, 9'd200, 0, 1'b0, 7, 33);
        check("abort_row6_written", pmem[9'd206], exp_w[6]);
        check("abort_row7_untouched", pmem[9'd207], {8{16'h5A5A}});

        set_ramp(-60, 1'b1);
        run_pass("single_pass_relu", 1'b1, 1'b1, 9'd300, 0, 1'b0, NROW, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
